// File: rtl/regfile_2w2r_sb_pkg.sv
// rtl/regfile_2w2r_sb_pkg.sv - shared defaults and types for the 2-write/2-read register file
package regfile_2w2r_sb_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = '0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_WIDTH-1:0]  data_word_t;

endpackage

// File: rtl/regfile_2w2r_sb_read_port.sv
// rtl/regfile_2w2r_sb_read_port.sv - one read port: data mux, busy lookup, optional bypass (REGFILE_BYPASS_EN)
module regfile_read_port
  import regfile_2w2r_sb_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DEPTH   = 2 ** ADDR_W,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic [WIDTH-1:0]  regs_i [DEPTH],
  input  logic [DEPTH-1:0]  busy_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] wa0_i,
  input  logic [WIDTH-1:0]  wd0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] wa1_i,
  input  logic [WIDTH-1:0]  wd1_i,
  input  logic              sv_i,
  input  logic [ADDR_W-1:0] sa_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              busy_o
);

`ifndef REGFILE_BYPASS_EN
  // Write and issue signals only matter when forwarding is built in.
  logic unused_fwd;
  assign unused_fwd = ^{we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i, sv_i, sa_i};
`endif

  // Select stored (or forwarded) data and busy bit; r0 is forced quiet when hardwired.
  always_comb begin
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    // Port 1 forwards ahead of port 0, matching its priority on the array.
    // A retiring write reads not-busy unless a new producer issues to it now.
    if (we1_i && (wa1_i == addr_i)) begin
      data_o = wd1_i;
      busy_o = sv_i && (sa_i == addr_i);
    end else if (we0_i && (wa0_i == addr_i)) begin
      data_o = wd0_i;
      busy_o = sv_i && (sa_i == addr_i);
    end
`endif
    if (ZERO_R0 && (addr_i == '0)) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_2w2r_sb.sv
// rtl/regfile_2w2r_sb.sv - 2-write/2-read register file with busy scoreboard; bypass via REGFILE_BYPASS_EN
module regfile_2w2r_sb
  import regfile_2w2r_sb_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      ADDR_W    = DEF_ADDR_W,
  parameter bit               ZERO_R0   = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RW0,
  input  logic [ADDR_W-1:0] DA0,
  input  logic [WIDTH-1:0]  D0,
  input  logic              RW1,
  input  logic [ADDR_W-1:0] DA1,
  input  logic [WIDTH-1:0]  D1,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  input  logic              SV,
  input  logic [ADDR_W-1:0] SA,
  output logic [WIDTH-1:0]  Aout,
  output logic [WIDTH-1:0]  Bout,
  output logic              Abusy,
  output logic              Bbusy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] reg_q [DEPTH];
  logic [WIDTH-1:0] reg_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr0_ok;
  logic wr1_ok;
  logic sv_ok;

  // With a hardwired r0, anything aimed at address 0 is dropped.
  assign wr0_ok = RW0 && !(ZERO_R0 && (DA0 == '0));
  assign wr1_ok = RW1 && !(ZERO_R0 && (DA1 == '0));
  assign sv_ok  = SV  && !(ZERO_R0 && (SA  == '0));

  // Next state: port 0 then port 1 (port 1 wins a collision), then issue sets busy last.
  always_comb begin
    reg_d  = reg_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      reg_d[DA0]  = D0;
      busy_d[DA0] = 1'b0;
    end
    if (wr1_ok) begin
      reg_d[DA1]  = D1;
      busy_d[DA1] = 1'b0;
    end
    if (sv_ok) begin
      busy_d[SA] = 1'b1;
    end
  end

  // Array and scoreboard registers; reset discards any same-cycle write or issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= RESET_VAL;
      end
      busy_q <= '0;
    end else begin
      reg_q  <= reg_d;
      busy_q <= busy_d;
    end
  end

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0)
  ) u_port_a (
    .regs_i (reg_q),
    .busy_i (busy_q),
    .addr_i (AA),
    .we0_i  (RW0),
    .wa0_i  (DA0),
    .wd0_i  (D0),
    .we1_i  (RW1),
    .wa1_i  (DA1),
    .wd1_i  (D1),
    .sv_i   (SV),
    .sa_i   (SA),
    .data_o (Aout),
    .busy_o (Abusy)
  );

  regfile_read_port #(
    .WIDTH   (WIDTH),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0)
  ) u_port_b (
    .regs_i (reg_q),
    .busy_i (busy_q),
    .addr_i (BA),
    .we0_i  (RW0),
    .wa0_i  (DA0),
    .wd0_i  (D0),
    .we1_i  (RW1),
    .wa1_i  (DA1),
    .wd1_i  (D1),
    .sv_i   (SV),
    .sa_i   (SA),
    .data_o (Bout),
    .busy_o (Bbusy)
  );

endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Parametrised next-generation register file for the datapath: configurable width and depth, two write ports, two asynchronous read ports, and a per-register busy scoreboard for the issue stage.
- Read side keeps the existing AA/BA to Aout/Bout contract; write-back from two producers (ALU, load unit) lands through D0/D1.
- Scoreboard bits are set at issue and cleared on write-back, letting control stall on RAW hazards.

Parameters:
- WIDTH, 16, data width of each register.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- ZERO_R0, 0, when 1 register 0 reads as 0, ignores writes, and is never busy.
- RESET_VAL, 0, value loaded into every register on reset (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- RW0  in  1  write enable, port 0.
- DA0  in  ADDR_W  write address, port 0.
- D0  in  WIDTH  write data, port 0.
- RW1  in  1  write enable, port 1.
- DA1  in  ADDR_W  write address, port 1.
- D1  in  WIDTH  write data, port 1.
- AA  in  ADDR_W  read address A.
- BA  in  ADDR_W  read address B.
- SV  in  1  scoreboard set valid (issue).
- SA  in  ADDR_W  scoreboard set address.
- Aout  out  WIDTH  contents of register AA (combinational).
- Bout  out  WIDTH  contents of register BA (combinational).
- Abusy  out  1  busy bit of register AA.
- Bbusy  out  1  busy bit of register BA.

Behaviour:
- One clock, synchronous active-high reset; all state updates on rising clk.
- Reset: every register loads RESET_VAL; all busy bits clear. Cycle after reset: Aout/Bout = RESET_VAL (0 for r0 if ZERO_R0), Abusy/Bbusy = 0.
- Reset has priority over everything: RW0/RW1/SV in a reset cycle are discarded. Reset mid-sequence clears pending busy bits; later write-backs to those registers write normally.
- Write: on the edge with RWn=1, reg[DAn] <= Dn and busy[DAn] <= 0. Latency 1; without bypass, new value is visible on Aout/Bout after that edge.
- Write collision (RW0=RW1=1, DA0==DA1): port 1 wins; port 0 data dropped; busy cleared.
- Scoreboard: SV=1 sets busy[SA] on the edge.
- SV and a write in the same cycle to the same address: set wins, busy=1 and data is written. This models a new producer issuing as the old one retires.
- Reads are purely combinational from array state; AA==BA is legal and both ports show the same value.
- ZERO_R0=1: writes and SV to address 0 are ignored; Aout/Bout = 0 and busy = 0 for address 0.
- Address range is always exactly DEPTH, so there are no out-of-range addresses.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a same-cycle write to AA/BA is forwarded combinationally. Aout = D1 if RW1 && DA1==AA, else D0 if RW0 && DA0==AA, else reg[AA]; Bout likewise.
- Defined: Abusy/Bbusy read 0 for a register being written that cycle, unless SV targets it.
- Defined: r0 with ZERO_R0 is never forwarded.
- Not defined: no forwarding; outputs reflect stored state only.

Decomposition:
- Shared package: WIDTH/ADDR_W defaults, register-address typedef, data-word typedef, RESET_VAL default.
- One natural sub-module, regfile_read_port: mux, optional bypass, and busy lookup. Instantiated twice (A, B).

Test Plan:
- Reset: pulse reset with RESET_VAL=0 -> Aout=Bout=0 and Abusy=Bbusy=0 for all 16 addresses.
- Write/read: RW0=1, DA0=3, D0=16'h00A5 for one edge, then AA=3, BA=3 -> Aout=Bout=16'h00A5. Without bypass, the prior cycle still shows 0.
- Collision: RW0=RW1=1, DA0=DA1=5, D0=16'h1111, D1=16'h2222 -> reg5=16'h2222.
- Scoreboard: SV=1, SA=7 -> Abusy=1 at AA=7. Next, RW1=1, DA1=7 -> Abusy=0. Then SV=1 and RW0=1 both to 7 in one cycle -> Abusy=1 and data written.
- ZERO_R0=1: RW0=1, DA0=0, D0=16'hFFFF and SV=1, SA=0 -> Aout=0, Abusy=0 at AA=0.
- Mid-operation reset: busy[2]=1 and reg2=16'h0042, then assert reset with RW0=1 to reg2 -> reg2=0, busy[2]=0.
- Bypass (REGFILE_BYPASS_EN defined): RW0=1, DA0=9, D0=16'h0BAD with AA=9 in the same cycle -> Aout=16'h0BAD before the edge.
